// File: rtl/enemy_4_sprite_fetch.sv
// Per-pixel sprite fetch for enemy type 4: frame-latched position, walk animation,
// death blink, sprite ROM addressing and a fixed two-cycle colour/hit pipeline.
module enemy_4_sprite_fetch #(
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int FRAMES      = 4,
  parameter int FRAME_TICKS = 8,
  parameter int DIE_TICKS   = 32,
  parameter int ADDR_W      = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              vsync_tick,
  input  logic [9:0]        enemy_x,
  input  logic [9:0]        enemy_y,
  input  logic [1:0]        dir,
  input  logic              moving,
  input  logic              alive,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic              active_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pal_index,
  output logic              pix_on,
  output logic              pix_valid
);

  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);
  localparam int FW = $clog2(FRAMES);
  localparam int TW = $clog2(FRAME_TICKS);
  localparam int DW = $clog2(DIE_TICKS);

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_DYING = 2'd1,
    ST_GONE  = 2'd2
  } life_t;

  life_t           state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [DW-1:0]   die_q, die_d;
  logic [9:0]      lx_q, ly_q;
  logic [1:0]      ldir_q;
  logic            hit_q, act_q;

  logic [10:0]     dx_s, dy_s;
  logic            hit_s, visible_s;

  // Shadow copies change only at vertical blank so a frame never tears.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lx_q   <= 10'd0;
      ly_q   <= 10'd0;
      ldir_q <= 2'd0;
    end else if (vsync_tick) begin
      lx_q   <= enemy_x;
      ly_q   <= enemy_y;
      ldir_q <= dir;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_GONE;
      tick_q  <= '0;
      frame_q <= '0;
      die_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
      die_q   <= die_d;
    end
  end

  // Death takes priority over the walk step on the same tick.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    frame_d = frame_q;
    die_d   = die_q;
    if (vsync_tick) begin
      case (state_q)
        ST_ALIVE: begin
          if (!alive) begin
            state_d = ST_DYING;
            die_d   = '0;
          end else if (moving) begin
            if (tick_q == TW'(FRAME_TICKS - 1)) begin
              tick_d  = '0;
              frame_d = frame_q + FW'(1);
            end else begin
              tick_d  = tick_q + TW'(1);
            end
          end else begin
            tick_d  = '0;
            frame_d = '0;
          end
        end
        ST_DYING: begin
          if (alive) begin
            state_d = ST_ALIVE;
            tick_d  = '0;
            frame_d = '0;
          end else if (die_q == DW'(DIE_TICKS - 1)) begin
            state_d = ST_GONE;
          end else begin
            die_d   = die_q + DW'(1);
          end
        end
        ST_GONE: begin
          if (alive) begin
            state_d = ST_ALIVE;
            tick_d  = '0;
            frame_d = '0;
          end else begin
            state_d = ST_GONE;
          end
        end
        default: state_d = ST_GONE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Negative offsets wrap to large unsigned values, so the screen edge never wraps a sprite.
  assign dx_s      = {1'b0, draw_x} - {1'b0, lx_q};
  assign dy_s      = {1'b0, draw_y} - {1'b0, ly_q};
  assign hit_s     = (dx_s < 11'(SPRITE_W)) && (dy_s < 11'(SPRITE_H));
  assign visible_s = (state_q == ST_ALIVE) || ((state_q == ST_DYING) && !die_q[1]);
  assign rom_addr  = (hit_s && !Reset) ? {ldir_q, frame_q, dy_s[YW-1:0], dx_s[XW-1:0]}
                                       : {ADDR_W{1'b0}};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_q     <= 1'b0;
      act_q     <= 1'b0;
      pal_index <= 4'd0;
      pix_on    <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      hit_q     <= hit_s & visible_s & active_in;
      act_q     <= active_in;
      pal_index <= rom_data;
      pix_on    <= hit_q & (rom_data != 4'd0);
      pix_valid <= act_q;
    end
  end

endmodule
